// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for the pixel pipeline. Walks an H_TOTAL x V_TOTAL
// raster one pixel per clk cycle with pix_en high, and provides the current
// coordinates, a visible-area flag, line/frame strobes and display syncs.
// Defaults describe 640x480@60 (800x525 total).
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   pix_en      in   pixel advance enable (one pixel step per enabled cycle)
//   video_x     out  current horizontal count, 0..H_TOTAL-1
//   video_y     out  current vertical count,   0..V_TOTAL-1
//   disp_active out  high while the current pixel is visible
//   line_end    out  one-clk strobe on the last pixel of each line
//   frame_end   out  one-clk strobe on the last pixel of each frame
//   hsync       out  horizontal sync, asserted level SYNC_POL
//   vsync       out  vertical sync, asserted level SYNC_POL
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] video_x,
  output logic [9:0] video_y,
  output logic       disp_active,
  output logic       line_end,
  output logic       frame_end,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("video_timing_gen: H_TOTAL (%0d) and V_TOTAL (%0d) must be <= 1024",
             H_TOTAL, V_TOTAL);
    end
  endgenerate

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds are one bit wider than the counters: a sync pulse may end
  // exactly at a total of 1024 when the back porch is zero.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_disp_active;
  logic       r_hsync;
  logic       r_vsync;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic       w_disp_next;
  logic       w_hsync_next;
  logic       w_vsync_next;
  logic       w_line_end;

  // Next counter values and the decodes of those values, so the registered
  // flags line up with video_x/video_y in the same cycle.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);

    w_h_next = w_h_wrap ? 10'd0 : (r_h_cnt + 10'd1);
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? 10'd0 : (r_v_cnt + 10'd1);
    end

    w_h_ext = {1'b0, w_h_next};
    w_v_ext = {1'b0, w_v_next};

    w_disp_next  = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
    w_hsync_next = ((w_h_ext >= HS_BEG) && (w_h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_next = ((w_v_ext >= VS_BEG) && (w_v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Reset parks the raster on its last pixel so the first enabled step
  // lands on (0,0) and raises both strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_disp_active <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
    end else if (pix_en) begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_disp_active <= w_disp_next;
      r_hsync       <= w_hsync_next;
      r_vsync       <= w_vsync_next;
    end
  end

  // Strobes mark the cycle in which the wrap is taken; gating with pix_en
  // keeps them one clk wide at any enable duty, and with reset keeps them
  // quiet while the counters are parked on the last pixel.
  assign w_line_end = pix_en && !reset && w_h_wrap;

  assign video_x     = r_h_cnt;
  assign video_y     = r_v_cnt;
  assign disp_active = r_disp_active;
  assign line_end    = w_line_end;
  assign frame_end   = w_line_end && w_v_wrap;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic pix_en = 1'b0;

  logic [9:0] vx [3];
  logic [9:0] vy [3];
  logic       act [3];
  logic       le [3];
  logic       fe [3];
  logic       hs [3];
  logic       vs [3];

  // dut 0: default 640x480, active-low syncs
  video_timing_gen u0 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .video_x(vx[0]), .video_y(vy[0]), .disp_active(act[0]),
    .line_end(le[0]), .frame_end(fe[0]), .hsync(hs[0]), .vsync(vs[0])
  );

  // dut 1: medium raster 32x22 so whole frames fit in the run, active-low
  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(5), .SYNC_POL(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .video_x(vx[1]), .video_y(vy[1]), .disp_active(act[1]),
    .line_end(le[1]), .frame_end(fe[1]), .hsync(hs[1]), .vsync(vs[1])
  );

  // dut 2: small raster 14x7, active-high syncs
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u2 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .video_x(vx[2]), .video_y(vy[2]), .disp_active(act[2]),
    .line_end(le[2]), .frame_end(fe[2]), .hsync(hs[2]), .vsync(vs[2])
  );

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit pol;
  } cfg_t;

  typedef struct {
    logic        rs;
    logic        en;
    logic [24:0] exp;
  } vec_t;

  cfg_t cfg [3];
  int   idx [3];   // linear pixel index = y*H_TOTAL + x
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // measurement trackers
  bit   meas = 1'b0;
  int   per = 1;
  int   last_le [3];
  int   last_fe [3];
  int   n_le [3];
  int   n_fe [3];
  int   n_hs [3];
  int   n_vs [3];
  int   hs_run [3];
  int   vs_run [3];
  bit   prev_hs [3];
  bit   prev_vs [3];
  bit   prev_act [3];

  vec_t tbl [10];

  function automatic int tot_h(int d);
    return cfg[d].ha + cfg[d].hfp + cfg[d].hsw + cfg[d].hbp;
  endfunction

  function automatic int tot_v(int d);
    return cfg[d].va + cfg[d].vfp + cfg[d].vsw + cfg[d].vbp;
  endfunction

  function automatic logic [24:0] mk(int x, int y, logic [4:0] b);
    return {10'(x), 10'(y), b};
  endfunction

  // Expected {x, y, active, line_end, frame_end, hsync, vsync} from the
  // linear raster position.
  function automatic logic [24:0] expv(int d, int i, logic en, logic rs);
    int h, v, x, y;
    logic a, l, f, hsy, vsy;
    h   = tot_h(d);
    v   = tot_v(d);
    x   = i % h;
    y   = i / h;
    a   = (x < cfg[d].ha) && (y < cfg[d].va);
    l   = en && !rs && (x == h - 1);
    f   = l && (i == h * v - 1);
    hsy = (x >= cfg[d].ha + cfg[d].hfp && x < cfg[d].ha + cfg[d].hfp + cfg[d].hsw) ?
          cfg[d].pol : !cfg[d].pol;
    vsy = (y >= cfg[d].va + cfg[d].vfp && y < cfg[d].va + cfg[d].vfp + cfg[d].vsw) ?
          cfg[d].pol : !cfg[d].pol;
    return mk(x, y, {a, l, f, hsy, vsy});
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: cyc=%0d got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic cmp_vec(string nm, int d, logic [24:0] got, logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got x=%0d y=%0d a/le/fe/hs/vs=%b expected x=%0d y=%0d a/le/fe/hs/vs=%b",
               nm, d, cyc, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic clear_meas(int p);
    per = p;
    for (int d = 0; d < 3; d++) begin
      last_le[d] = -1; last_fe[d] = -1;
      n_le[d] = 0; n_fe[d] = 0; n_hs[d] = 0; n_vs[d] = 0;
      hs_run[d] = 0; vs_run[d] = 0;
      prev_hs[d] = 1'b0; prev_vs[d] = 1'b0; prev_act[d] = 1'b0;
    end
  endtask

  task automatic measure();
    for (int d = 0; d < 3; d++) begin
      int  h, v;
      bit  hs_a, vs_a;
      h    = tot_h(d);
      v    = tot_v(d);
      hs_a = (hs[d] == cfg[d].pol);
      vs_a = (vs[d] == cfg[d].pol);
      if (le[d]) begin
        if (last_le[d] >= 0) chk("line_end period", cyc - last_le[d], h * per);
        last_le[d] = cyc;
        n_le[d]++;
      end
      if (fe[d]) begin
        if (last_fe[d] >= 0) chk("frame_end period", cyc - last_fe[d], h * v * per);
        last_fe[d] = cyc;
        n_fe[d]++;
      end
      if (hs_a && !prev_hs[d]) begin
        chk("hsync start x", int'(vx[d]), cfg[d].ha + cfg[d].hfp);
        hs_run[d] = 0;
      end
      if (hs_a) hs_run[d]++;
      if (!hs_a && prev_hs[d]) begin
        chk("hsync width", hs_run[d], cfg[d].hsw * per);
        n_hs[d]++;
      end
      if (vs_a && !prev_vs[d]) begin
        chk("vsync start x", int'(vx[d]), 0);
        chk("vsync start y", int'(vy[d]), cfg[d].va + cfg[d].vfp);
        vs_run[d] = 0;
      end
      if (vs_a) vs_run[d]++;
      if (!vs_a && prev_vs[d]) begin
        chk("vsync width", vs_run[d], cfg[d].vsw * h * per);
        n_vs[d]++;
      end
      if (!act[d] && prev_act[d]) chk("disp_active fall x", int'(vx[d]), cfg[d].ha);
      prev_hs[d]  = hs_a;
      prev_vs[d]  = vs_a;
      prev_act[d] = act[d];
    end
  endtask

  // One clk cycle: drive on the falling edge, sample 1 ns later, then let
  // the model take the rising edge.
  task automatic tick(input logic en, input logic rs, input bit use_t,
                      input logic [24:0] t_exp);
    @(negedge clk);
    reset  = rs;
    pix_en = en;
    if (rs) for (int d = 0; d < 3; d++) idx[d] = tot_h(d) * tot_v(d) - 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      cmp_vec("model", d, {vx[d], vy[d], act[d], le[d], fe[d], hs[d], vs[d]},
              expv(d, idx[d], en, rs));
    end
    if (use_t) cmp_vec("table", 0, {vx[0], vy[0], act[0], le[0], fe[0], hs[0], vs[0]}, t_exp);
    if (meas) measure();
    @(posedge clk);
    cyc++;
    if (!reset && pix_en) begin
      for (int d = 0; d < 3; d++) idx[d] = (idx[d] + 1) % (tot_h(d) * tot_v(d));
    end
  endtask

  task automatic run_phase(int p, int n);
    meas = 1'b0;
    tick(1'b0, 1'b1, 1'b0, '0);
    clear_meas(p);
    meas = 1'b1;
    for (int k = 0; k < n; k++) tick((p == 1) || (k % 2 == 0), 1'b0, 1'b0, '0);
    meas = 1'b0;
    chk("line_end count dut0", int'(n_le[0] >= 3), 1);
    chk("frame_end count dut1", int'(n_fe[1] >= 2), 1);
    chk("hsync pulses dut0", int'(n_hs[0] >= 1), 1);
    chk("vsync pulses dut1", int'(n_vs[1] >= 1), 1);
    chk("vsync pulses dut2", int'(n_vs[2] >= 1), 1);
  endtask

  initial begin
    cfg[0] = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, pol:1'b0};
    cfg[1] = '{ha:16,  hfp:4,  hsw:6,  hbp:6,  va:12,  vfp:3,  vsw:2, vbp:5,  pol:1'b0};
    cfg[2] = '{ha:8,   hfp:2,  hsw:2,  hbp:2,  va:4,   vfp:1,  vsw:1, vbp:1,  pol:1'b1};
    for (int d = 0; d < 3; d++) idx[d] = tot_h(d) * tot_v(d) - 1;
    clear_meas(1);

    // {reset, pix_en, expected dut0 outputs}; bits are a/le/fe/hs/vs
    tbl[0] = '{rs:1'b1, en:1'b1, exp:mk(799, 524, 5'b00011)};
    tbl[1] = '{rs:1'b1, en:1'b0, exp:mk(799, 524, 5'b00011)};
    tbl[2] = '{rs:1'b0, en:1'b1, exp:mk(799, 524, 5'b01111)};
    tbl[3] = '{rs:1'b0, en:1'b0, exp:mk(0,   0,   5'b10011)};
    tbl[4] = '{rs:1'b0, en:1'b1, exp:mk(0,   0,   5'b10011)};
    tbl[5] = '{rs:1'b0, en:1'b1, exp:mk(1,   0,   5'b10011)};
    tbl[6] = '{rs:1'b0, en:1'b0, exp:mk(2,   0,   5'b10011)};
    tbl[7] = '{rs:1'b1, en:1'b1, exp:mk(799, 524, 5'b00011)};
    tbl[8] = '{rs:1'b0, en:1'b1, exp:mk(799, 524, 5'b01111)};
    tbl[9] = '{rs:1'b0, en:1'b0, exp:mk(0,   0,   5'b10011)};

    for (int i = 0; i < 10; i++) tick(tbl[i].en, tbl[i].rs, 1'b1, tbl[i].exp);

    // randomized enable pattern with rare resets
    for (int k = 0; k < 5000; k++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 999) == 0), 1'b0, '0);
    end

    // continuous enable, then enable on every second clk
    run_phase(1, 1700);
    run_phase(2, 3400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
